rng_stream_gen: RTL and testbench

- Parametrised multi-lane random-data generator: fills a memory region with pseudo-random data over the AXI write channels.
- Configured and polled through the soft register interface.
- Generalises the single-stream RNG block: NUM_LANES independent 64-bit xorshift lanes form each DATA_WIDTH beat, burst length is configurable, and status/error reporting is added.
- Sits under the per-app wrapper. The read channels are not used; the wrapper ties them off.

---
 rtl/rng_stream_gen_if.sv | 36 +++
 rtl/rng_stream_gen.sv | 252 +++++++++++++++++++++++++
 tb/tb_rng_stream_gen.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rng_stream_gen_if.sv
// AXI write-channel bundle for rng_stream_gen: AW, W and B channels only.
// The generator is the master; the memory side (or a bench) is the slave.
`timescale 1ns/1ps
interface rng_stream_gen_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 16
);
    logic [ID_WIDTH-1:0]     awid_m;
    logic [ADDR_WIDTH-1:0]   awaddr_m;
    logic [7:0]              awlen_m;
    logic [2:0]              awsize_m;
    logic                    awvalid_m;
    logic                    awready_m;
    logic [DATA_WIDTH-1:0]   wdata_m;
    logic [DATA_WIDTH/8-1:0] wstrb_m;
    logic                    wlast_m;
    logic                    wvalid_m;
    logic                    wready_m;
    logic [ID_WIDTH-1:0]     bid_m;
    logic [1:0]              bresp_m;
    logic                    bvalid_m;
    logic                    bready_m;

    modport master (
        output awid_m, awaddr_m, awlen_m, awsize_m, awvalid_m,
        output wdata_m, wstrb_m, wlast_m, wvalid_m, bready_m,
        input  awready_m, wready_m, bid_m, bresp_m, bvalid_m
    );

    modport slave (
        input  awid_m, awaddr_m, awlen_m, awsize_m, awvalid_m,
        input  wdata_m, wstrb_m, wlast_m, wvalid_m, bready_m,
        output awready_m, wready_m, bid_m, bresp_m, bvalid_m
    );
endinterface

// File: rtl/rng_stream_gen.sv
// rng_stream_gen: fills a memory region with xorshift64 pseudo-random data
// through AXI write bursts, one burst outstanding at a time. Configured and
// polled through the soft register port.
// Optional feature macro: RNG_STREAM_CHECKSUM_EN adds a 64-bit XOR checksum
// of all written lane slices, readable at 0x20.
`timescale 1ns/1ps
module rng_stream_gen #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_LANES  = DATA_WIDTH / 64,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 16,
    parameter int BURST_LEN  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rng_stream_gen_if.master       axi,
    input  logic                   softreg_req_valid,
    input  logic                   softreg_req_isWrite,
    input  logic [31:0]            softreg_req_addr,
    input  logic [63:0]            softreg_req_data,
    output logic                   softreg_resp_valid,
    output logic [63:0]            softreg_resp_data
);

    localparam int BYTE_SHIFT  = $clog2(DATA_WIDTH / 8);
    localparam int BURST_SHIFT = $clog2(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [63:0] BASE_MASK = ~((64'd1 << BURST_SHIFT) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

    state_t                       r_state;
    state_t                       w_nextState;
    logic [63:0]                  r_base;
    logic [63:0]                  r_len;
    logic [63:0]                  r_seed;
    logic [63:0]                  r_beatsLeft;
    logic [NUM_LANES-1:0][63:0]   r_lanes;
    logic [NUM_LANES-1:0][63:0]   w_seedLanes;
    logic [NUM_LANES-1:0][63:0]   w_nextLanes;
    logic [ADDR_WIDTH-1:0]        r_nextAddr;
    logic [7:0]                   r_awlen;
    logic [7:0]                   r_beatIdx;
    logic [7:0]                   w_burstBeats;
    logic [31:0]                  r_beatCount;
    logic [32:0]                  w_countSum;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_err;
    logic [63:0]                  w_lenBeats;
    logic [63:0]                  w_beatsAfter;
    logic [2:0]                   w_sel;
    logic                         w_regWrite;
    logic                         w_start;
    logic                         w_awFire;
    logic                         w_wFire;
    logic                         w_bFire;
    logic [63:0]                  w_readData;
    logic                         w_unused;
`ifdef RNG_STREAM_CHECKSUM_EN
    logic [63:0]                  r_checksum;
    logic [63:0]                  w_laneXor;
`endif

    function automatic logic [63:0] xorshift64(input logic [63:0] x);
        logic [63:0] v;
        v = x ^ (x << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

    function automatic logic [63:0] seedLane(input logic [63:0] seed, input int idx);
        logic [63:0] mixed;
        mixed = seed ^ (64'(idx) * GOLDEN);
        return (mixed == 64'd0) ? 64'd1 : mixed;
    endfunction

    assign w_sel        = softreg_req_addr[5:3];
    assign w_regWrite   = softreg_req_valid & softreg_req_isWrite;
    assign w_start      = w_regWrite && (w_sel == 3'd3) && (r_state == S_IDLE);
    assign w_lenBeats   = r_len >> BYTE_SHIFT;
    assign w_burstBeats = (r_beatsLeft >= 64'(BURST_LEN)) ? 8'(BURST_LEN) : r_beatsLeft[7:0];
    assign w_beatsAfter = r_beatsLeft - {56'd0, r_awlen} - 64'd1;
    assign w_countSum   = {1'b0, r_beatCount} + {25'd0, r_awlen} + 33'd1;
    assign w_awFire     = (r_state == S_ADDR) && axi.awready_m;
    assign w_wFire      = (r_state == S_DATA) && axi.wready_m;
    assign w_bFire      = (r_state == S_RESP) && axi.bvalid_m;
    assign w_unused     = ^{axi.bid_m, softreg_req_addr[31:6], softreg_req_addr[2:0]};

    assign axi.awid_m   = '0;
    assign axi.awaddr_m = r_nextAddr;
    assign axi.awlen_m  = w_burstBeats - 8'd1;
    assign axi.awsize_m = 3'(BYTE_SHIFT);
    assign axi.wdata_m  = r_lanes;
    assign axi.wstrb_m  = '1;
    assign axi.wlast_m  = (r_state == S_DATA) && (r_beatIdx == r_awlen);

    // Seed values for a new run and the next state of every lane.
    always_comb begin
        w_seedLanes = '0;
        w_nextLanes = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_seedLanes[i] = seedLane(r_seed, i);
            w_nextLanes[i] = xorshift64(r_lanes[i]);
        end
    end

`ifdef RNG_STREAM_CHECKSUM_EN
    // XOR of all lane slices in the current beat, folded into the checksum.
    always_comb begin
        w_laneXor = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_laneXor = w_laneXor ^ r_lanes[i];
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next state and the channel valid/ready outputs.
    always_comb begin
        w_nextState   = r_state;
        axi.awvalid_m = 1'b0;
        axi.wvalid_m  = 1'b0;
        axi.bready_m  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_nextState = (w_lenBeats != 64'd0) ? S_ADDR : S_DONE;
                end
            end
            S_ADDR: begin
                axi.awvalid_m = 1'b1;
                if (axi.awready_m) begin
                    w_nextState = S_DATA;
                end
            end
            S_DATA: begin
                axi.wvalid_m = 1'b1;
                if (axi.wready_m && (r_beatIdx == r_awlen)) begin
                    w_nextState = S_RESP;
                end
            end
            S_RESP: begin
                axi.bready_m = 1'b1;
                if (axi.bvalid_m) begin
                    w_nextState = (w_beatsAfter != 64'd0) ? S_ADDR : S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Soft register read mux.
    always_comb begin
        w_readData = '0;
        case (w_sel)
            3'd0:    w_readData = r_base;
            3'd1:    w_readData = r_len;
            3'd2:    w_readData = r_seed;
            3'd3:    w_readData = {r_beatCount, 29'd0, r_err, r_done, r_busy};
`ifdef RNG_STREAM_CHECKSUM_EN
            3'd4:    w_readData = r_checksum;
`endif
            default: w_readData = '0;
        endcase
    end

    // Configuration registers, run state, lane generators and read response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base             <= '0;
            r_len              <= '0;
            r_seed             <= '0;
            r_beatsLeft        <= '0;
            r_lanes            <= '0;
            r_nextAddr         <= '0;
            r_awlen            <= '0;
            r_beatIdx          <= '0;
            r_beatCount        <= '0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_err              <= 1'b0;
            softreg_resp_valid <= 1'b0;
            softreg_resp_data  <= '0;
`ifdef RNG_STREAM_CHECKSUM_EN
            r_checksum         <= '0;
`endif
        end else begin
            if (w_regWrite) begin
                case (w_sel)
                    3'd0:    r_base <= softreg_req_data & BASE_MASK;
                    3'd1:    r_len  <= softreg_req_data;
                    3'd2:    r_seed <= softreg_req_data;
                    default: ;
                endcase
            end
            if (w_start) begin
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
                r_err       <= 1'b0;
                r_beatCount <= '0;
                r_beatsLeft <= w_lenBeats;
                r_nextAddr  <= ADDR_WIDTH'(r_base);
                r_lanes     <= w_seedLanes;
`ifdef RNG_STREAM_CHECKSUM_EN
                r_checksum  <= '0;
`endif
            end
            if (w_awFire) begin
                r_awlen    <= w_burstBeats - 8'd1;
                r_beatIdx  <= '0;
                r_nextAddr <= r_nextAddr + BURST_BYTES;
            end
            if (w_wFire) begin
                r_lanes    <= w_nextLanes;
                r_beatIdx  <= r_beatIdx + 8'd1;
`ifdef RNG_STREAM_CHECKSUM_EN
                r_checksum <= r_checksum ^ w_laneXor;
`endif
            end
            if (w_bFire) begin
                if (axi.bresp_m != 2'b00) begin
                    r_err <= 1'b1;
                end
                r_beatCount <= w_countSum[32] ? 32'hFFFF_FFFF : w_countSum[31:0];
                r_beatsLeft <= w_beatsAfter;
            end
            if (r_state == S_DONE) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            softreg_resp_valid <= softreg_req_valid & ~softreg_req_isWrite;
            softreg_resp_data  <= (softreg_req_valid & ~softreg_req_isWrite) ? w_readData : 64'd0;
        end
    end

endmodule

// File: tb/tb_rng_stream_gen.sv
// Self-checking bench for rng_stream_gen: an AXI write slave with optional
// stalls and error responses, a scoreboard of expected AW and W beats built
// from an xorshift64 reference model, and directed soft-register steps.
`timescale 1ns/1ps
module tb_rng_stream_gen;

    localparam logic [63:0] GOLDEN   = 64'h9E3779B97F4A7C15;
    localparam logic [31:0] A_BASE   = 32'h00;
    localparam logic [31:0] A_LEN    = 32'h08;
    localparam logic [31:0] A_SEED   = 32'h10;
    localparam logic [31:0] A_CTRL   = 32'h18;
    localparam logic [31:0] A_SUM    = 32'h20;
    localparam logic [31:0] A_UNMAP  = 32'h28;

    typedef struct packed {
        logic [511:0] data;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } aw_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        softreg_req_valid = 1'b0;
    logic        softreg_req_isWrite = 1'b0;
    logic [31:0] softreg_req_addr = '0;
    logic [63:0] softreg_req_data = '0;
    logic        softreg_resp_valid;
    logic [63:0] softreg_resp_data;

    rng_stream_gen_if #(.DATA_WIDTH(512), .ADDR_WIDTH(64), .ID_WIDTH(16)) axi ();

    rng_stream_gen #(
        .DATA_WIDTH(512),
        .NUM_LANES(8),
        .ADDR_WIDTH(64),
        .ID_WIDTH(16),
        .BURST_LEN(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .axi(axi),
        .softreg_req_valid(softreg_req_valid),
        .softreg_req_isWrite(softreg_req_isWrite),
        .softreg_req_addr(softreg_req_addr),
        .softreg_req_data(softreg_req_data),
        .softreg_resp_valid(softreg_resp_valid),
        .softreg_resp_data(softreg_resp_data)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;
    beat_t        expW[$];
    aw_t          expAw[$];
    int           awCount = 0;
    int           runBeats = 0;
    int           burstsDone = 0;
    int           cyc = 0;
    bit           stallMode = 0;
    bit           awDelayMode = 0;
    bit           errMode = 0;
    bit           awSeen = 0;
    bit           overlapSeen = 0;
    logic [511:0] firstBeat = '0;
    logic [63:0]  modelChecksum = '0;

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] xs(input logic [63:0] x);
        logic [63:0] v;
        v = x ^ (x << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

    task automatic regWrite(input logic [31:0] addr, input logic [63:0] data);
        softreg_req_valid   = 1'b1;
        softreg_req_isWrite = 1'b1;
        softreg_req_addr    = addr;
        softreg_req_data    = data;
        @(negedge clk);
        softreg_req_valid   = 1'b0;
        softreg_req_isWrite = 1'b0;
    endtask

    task automatic regRead(input logic [31:0] addr, output logic [63:0] data, output logic valid);
        softreg_req_valid   = 1'b1;
        softreg_req_isWrite = 1'b0;
        softreg_req_addr    = addr;
        @(negedge clk);
        softreg_req_valid   = 1'b0;
        data  = softreg_resp_data;
        valid = softreg_resp_valid;
    endtask

    // Program a run, push the reference AW/W sequence to the scoreboard, start it.
    task automatic applyStimulus(input logic [63:0] base, input logic [63:0] len, input logic [63:0] seed);
        logic [63:0]  lanes [8];
        logic [63:0]  addr;
        logic [63:0]  rem;
        logic [63:0]  mixed;
        logic [511:0] beat;
        int           n;
        regWrite(A_BASE, base);
        regWrite(A_LEN, len);
        regWrite(A_SEED, seed);
        for (int i = 0; i < 8; i++) begin
            mixed    = seed ^ (64'(i) * GOLDEN);
            lanes[i] = (mixed == 64'd0) ? 64'd1 : mixed;
        end
        addr = base & ~64'h3FF;
        rem  = len >> 6;
        modelChecksum = '0;
        while (rem != 64'd0) begin
            n = (rem >= 64'd16) ? 16 : int'(rem);
            expAw.push_back('{addr: addr, len: 8'(n - 1)});
            for (int j = 0; j < n; j++) begin
                for (int i = 0; i < 8; i++) begin
                    beat[64*i +: 64] = lanes[i];
                    modelChecksum    = modelChecksum ^ lanes[i];
                    lanes[i]         = xs(lanes[i]);
                end
                expW.push_back('{data: beat, last: (j == n - 1)});
            end
            rem  = rem - 64'(n);
            addr = addr + 64'd1024;
        end
        awCount    = 0;
        runBeats   = 0;
        burstsDone = 0;
        awSeen     = 0;
        regWrite(A_CTRL, 64'd1);
    endtask

    task automatic waitDone(input string tag, output logic [63:0] status);
        logic v;
        bit   ok;
        ok = 0;
        status = '0;
        for (int i = 0; i < 400; i++) begin
            regRead(A_CTRL, status, v);
            if (status[1]) begin
                ok = 1;
                break;
            end
        end
        checkOutput({tag, "_done_seen"}, 512'(ok), 512'(1));
    endtask

    // AXI write slave with scoreboard comparison of every AW and W handshake.
    initial begin
        bit           pendingB;
        bit           clearB;
        bit           heldValid;
        logic [511:0] heldData;
        int           awWait;
        beat_t        eb;
        aw_t          ea;
        pendingB  = 0;
        clearB    = 0;
        heldValid = 0;
        heldData  = '0;
        awWait    = 0;
        axi.awready_m = 1'b0;
        axi.wready_m  = 1'b0;
        axi.bvalid_m  = 1'b0;
        axi.bresp_m   = 2'b00;
        axi.bid_m     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                axi.awready_m = 1'b0;
                axi.wready_m  = 1'b0;
                axi.bvalid_m  = 1'b0;
                pendingB  = 0;
                clearB    = 0;
                heldValid = 0;
                awWait    = 0;
                continue;
            end
            if (axi.awvalid_m) begin
                awSeen = 1;
                if (axi.wvalid_m) overlapSeen = 1;
            end
            if (clearB) begin
                axi.bvalid_m = 1'b0;
                clearB = 0;
            end
            if (pendingB) begin
                axi.bvalid_m = 1'b1;
                axi.bresp_m  = (errMode && burstsDone == 0) ? 2'b10 : 2'b00;
                pendingB = 0;
            end
            if (axi.bvalid_m && axi.bready_m) begin
                clearB = 1;
                burstsDone++;
            end
            axi.awready_m = (!awDelayMode) || (awWait >= 5);
            if (axi.awvalid_m) begin
                if (axi.awready_m) begin
                    awWait = 0;
                    awCount++;
                    checkOutput("aw_expected", 512'(expAw.size() != 0), 512'(1));
                    if (expAw.size() != 0) begin
                        ea = expAw.pop_front();
                        checkOutput("awaddr", 512'(axi.awaddr_m), 512'(ea.addr));
                        checkOutput("awlen", 512'(axi.awlen_m), 512'(ea.len));
                        checkOutput("awsize", 512'(axi.awsize_m), 512'(3'd6));
                        checkOutput("awid", 512'(axi.awid_m), 512'(16'd0));
                    end
                end else begin
                    awWait++;
                end
            end
            if (heldValid && axi.wvalid_m) begin
                checkOutput("wdata_stable", axi.wdata_m, heldData);
            end
            heldValid = 0;
            axi.wready_m = (!stallMode) || (cyc % 3 == 0);
            if (axi.wvalid_m && axi.wready_m) begin
                if (runBeats == 0) firstBeat = axi.wdata_m;
                runBeats++;
                checkOutput("w_expected", 512'(expW.size() != 0), 512'(1));
                if (expW.size() != 0) begin
                    eb = expW.pop_front();
                    checkOutput("wdata", axi.wdata_m, eb.data);
                    checkOutput("wlast", 512'(axi.wlast_m), 512'(eb.last));
                    checkOutput("wstrb", 512'(axi.wstrb_m), 512'({64{1'b1}}));
                end
                if (axi.wlast_m) pendingB = 1;
            end else if (axi.wvalid_m) begin
                heldValid = 1;
                heldData  = axi.wdata_m;
            end
        end
    end

    // Directed test sequence.
    initial begin
        logic [63:0] rd;
        logic [63:0] st;
        logic        v;
        bit          reached;

        repeat (3) @(negedge clk);
        checkOutput("rst_awvalid", 512'(axi.awvalid_m), 512'(0));
        checkOutput("rst_wvalid", 512'(axi.wvalid_m), 512'(0));
        checkOutput("rst_bready", 512'(axi.bready_m), 512'(0));
        checkOutput("rst_resp_valid", 512'(softreg_resp_valid), 512'(0));
        rst_n = 1'b1;
        @(negedge clk);
        regRead(A_CTRL, rd, v);
        checkOutput("rst_status", 512'(rd), 512'(0));
        checkOutput("read_resp_valid", 512'(v), 512'(1));
        @(negedge clk);
        checkOutput("read_resp_pulse", 512'(softreg_resp_valid), 512'(0));

        $display("[TB] base alignment and write response");
        regWrite(A_BASE, 64'h1234);
        checkOutput("write_no_resp", 512'(softreg_resp_valid), 512'(0));
        regRead(A_BASE, rd, v);
        checkOutput("base_masked", 512'(rd), 512'(64'h1000));
        regRead(A_UNMAP, rd, v);
        checkOutput("unmapped_read", 512'(rd), 512'(0));

        $display("[TB] single burst run");
        applyStimulus(64'h1000, 64'd1024, 64'd1);
        waitDone("run1", st);
        checkOutput("run1_status", 512'(st), 512'(64'h0000_0010_0000_0002));
        checkOutput("run1_aw_count", 512'(awCount), 512'(1));
        checkOutput("run1_beats", 512'(runBeats), 512'(16));
        checkOutput("run1_lane0_beat0", 512'(firstBeat[63:0]), 512'(64'h1));
        checkOutput("run1_lane1_beat0", 512'(firstBeat[127:64]), 512'(64'h9E3779B97F4A7C14));
        regRead(A_SUM, rd, v);
`ifdef RNG_STREAM_CHECKSUM_EN
        checkOutput("checksum", 512'(rd), 512'(modelChecksum));
`else
        checkOutput("checksum_absent", 512'(rd), 512'(0));
`endif

        $display("[TB] two burst run");
        applyStimulus(64'h1000, 64'd1600, 64'd1);
        waitDone("run2", st);
        checkOutput("run2_status", 512'(st), 512'(64'h0000_0019_0000_0002));
        checkOutput("run2_aw_count", 512'(awCount), 512'(2));
        checkOutput("run2_beats", 512'(runBeats), 512'(25));

        $display("[TB] zero length run");
        applyStimulus(64'h1000, 64'd0, 64'd1);
        @(negedge clk);
        regRead(A_CTRL, rd, v);
        checkOutput("len0_status", 512'(rd), 512'(64'h2));
        repeat (4) @(negedge clk);
        checkOutput("len0_no_aw", 512'(awSeen), 512'(0));

        $display("[TB] stalled run");
        stallMode   = 1;
        awDelayMode = 1;
        applyStimulus(64'h1000, 64'd1600, 64'd1);
        waitDone("stall", st);
        stallMode   = 0;
        awDelayMode = 0;
        checkOutput("stall_status", 512'(st), 512'(64'h0000_0019_0000_0002));
        checkOutput("stall_beats", 512'(runBeats), 512'(25));
        checkOutput("stall_queue_empty", 512'(expW.size()), 512'(0));

        $display("[TB] error response run");
        errMode = 1;
        applyStimulus(64'h1000, 64'd1600, 64'd1);
        waitDone("err", st);
        errMode = 0;
        checkOutput("err_status", 512'(st), 512'(64'h0000_0019_0000_0006));
        checkOutput("err_beats", 512'(runBeats), 512'(25));

        $display("[TB] start while busy");
        applyStimulus(64'h3000, 64'd1024, 64'd7);
        repeat (2) @(negedge clk);
        regWrite(A_SEED, 64'd99);
        regWrite(A_CTRL, 64'd1);
        waitDone("busy", st);
        checkOutput("busy_status", 512'(st), 512'(64'h0000_0010_0000_0002));
        checkOutput("busy_aw_count", 512'(awCount), 512'(1));
        checkOutput("busy_queue_empty", 512'(expW.size()), 512'(0));

        $display("[TB] reset mid-data");
        applyStimulus(64'h2000, 64'd1024, 64'd5);
        reached = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (runBeats >= 3) begin
                reached = 1;
                break;
            end
        end
        checkOutput("midrun_reached", 512'(reached), 512'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_awvalid", 512'(axi.awvalid_m), 512'(0));
        checkOutput("midrst_wvalid", 512'(axi.wvalid_m), 512'(0));
        checkOutput("midrst_bready", 512'(axi.bready_m), 512'(0));
        expW.delete();
        expAw.delete();
        regRead(A_CTRL, rd, v);
        checkOutput("midrst_status", 512'(rd), 512'(0));
        regRead(A_BASE, rd, v);
        checkOutput("midrst_base", 512'(rd), 512'(0));
        repeat (5) @(negedge clk);
        checkOutput("midrst_idle", 512'(axi.awvalid_m | axi.wvalid_m), 512'(0));

        checkOutput("aw_w_overlap", 512'(overlapSeen), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
